// File: rtl/tv_timing_gen.sv
// tv_timing_gen -- TV raster timing generator.
//
// Purpose: counts samples within a line (sc) and halflines within a field
// (hl), and decodes them into composite sync, blanking, colour-burst gate,
// PAL V-phase, field parity, field-start pulse and an OSD vertical pulse.
// A falling edge on ext_vs resynchronises the raster to the start of a
// field.
//
// Build option: define TV_INTERLACE_EN for interlaced fields of FIELD_HL
// halflines. Alternate fields then begin at mid-line. Without it, fields
// are FIELD_HL-1 halflines long and always begin at sample 0.
//
// Ports:
//   clk24        in   system clock (single domain)
//   reset_n      in   asynchronous active-low reset
//   ce           in   sample-rate clock enable
//   ext_vs       in   external vertical sync (falling edge resyncs)
//   alt_en       in   enable field-alternating PAL phase
//   tv_sync      out  composite sync, active low
//   tv_blank     out  blanking gate, 1 = blanked
//   tv_burst     out  colour-burst gate
//   line_alt     out  PAL V-phase select
//   field        out  field parity
//   field_start  out  one-ce pulse on the first sample of halfline 0
//   osd_vsync    out  active-low pulse for the whole of halfline OSD_HL
//   sample[10:0] out  sample position within the line
//   halfline[10:0] out halfline index within the field
//
// Every output is a register. It is loaded only on ce, from the counter
// state as it stood before that same ce advanced the counters. Outputs
// therefore lag the counters by one sample and stay frozen while ce=0.
module tv_timing_gen #(
   parameter int H_TOTAL    = 1536,
   parameter int HSYNC_LEN  = 114,
   parameter int BURST_OFS  = 24,
   parameter int BURST_LEN  = 75,
   parameter int BLANK_END  = 249,
   parameter int BLANK_TAIL = 40,
   parameter int FIELD_HL   = 625,
   parameter int OSD_HL     = 275
) (
   input  logic        clk24,
   input  logic        reset_n,
   input  logic        ce,
   input  logic        ext_vs,
   input  logic        alt_en,
   output logic        tv_sync,
   output logic        tv_blank,
   output logic        tv_burst,
   output logic        line_alt,
   output logic        field,
   output logic        field_start,
   output logic        osd_vsync,
   output logic [10:0] sample,
   output logic [10:0] halfline
);

`ifdef TV_INTERLACE_EN
   localparam int FL = FIELD_HL;
`else
   localparam int FL = FIELD_HL - 1;
`endif

   localparam logic [10:0] SC_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] HALF      = 11'(H_TOTAL / 2);
   localparam logic [10:0] HP_LAST   = 11'(H_TOTAL / 2 - 1);
   localparam logic [10:0] HL_LAST   = 11'(FL - 1);
   localparam logic [10:0] EQ_FROM   = 11'(FL - 7);
   localparam logic [10:0] BROAD_END = 11'(H_TOTAL / 2 - HSYNC_LEN + 1);
   localparam logic [10:0] EQUAL_END = 11'(HSYNC_LEN / 2);
   localparam logic [10:0] NORM_END  = 11'(HSYNC_LEN);
   localparam logic [10:0] BURST_LO  = 11'(HSYNC_LEN + BURST_OFS);
   localparam logic [10:0] BURST_HI  = 11'(HSYNC_LEN + BURST_OFS + BURST_LEN);
   localparam logic [10:0] BLANK_LO  = 11'(BLANK_END);
   localparam logic [10:0] BLANK_HI  = 11'(H_TOTAL - BLANK_TAIL);
   localparam logic [10:0] OSD_LINE  = 11'(OSD_HL);

   typedef enum logic [1:0] {
      ST_BROAD,
      ST_EQUAL,
      ST_NORMAL
   } sync_state_e;

   // Counter state
   logic [10:0] sc_q, sc_d;
   logic [10:0] hl_q, hl_d;
   logic        fld_q, fld_d;
   logic        fs_q, fs_d;     // field-start pending until the next ce
   logic        vs_q, vs_d;     // ext_vs history, sampled every clock

   // Output registers
   logic        tv_sync_q, tv_sync_d;
   logic        tv_blank_q, tv_blank_d;
   logic        tv_burst_q, tv_burst_d;
   logic        line_alt_q, line_alt_d;
   logic        field_q, field_d;
   logic        field_start_q, field_start_d;
   logic        osd_vsync_q, osd_vsync_d;
   logic [10:0] sample_q, sample_d;
   logic [10:0] halfline_q, halfline_d;

   logic [10:0] hp;
   logic        vs_fall;
   logic        fieldzone;
   sync_state_e sync_st;

   assign hp      = (sc_q >= HALF) ? (sc_q - HALF) : sc_q;
   assign vs_fall = vs_q & ~ext_vs;

   // Counter advance. The ext_vs edge takes priority over ce. It also
   // overrides a natural field wrap on the same clock, so field toggles
   // only once.
   always_comb begin
      sc_d  = sc_q;
      hl_d  = hl_q;
      fld_d = fld_q;
      fs_d  = fs_q;
      vs_d  = ext_vs;
      if (vs_fall) begin
         sc_d  = '0;
         hl_d  = '0;
         fld_d = ~fld_q;
         fs_d  = 1'b1;
      end else if (ce) begin
         fs_d = 1'b0;
         sc_d = (sc_q == SC_LAST) ? '0 : sc_q + 11'd1;
         if (hp == HP_LAST) begin
            if (hl_q == HL_LAST) begin
               hl_d  = '0;
               fld_d = ~fld_q;
               fs_d  = 1'b1;
            end else begin
               hl_d = hl_q + 11'd1;
            end
         end
      end
   end

   // Per-halfline sync shape and output decode
   always_comb begin
      sync_st = ST_NORMAL;
      if (hl_q <= 11'd4) begin
         sync_st = ST_BROAD;
      end else if ((hl_q <= 11'd9) || (hl_q >= EQ_FROM)) begin
         sync_st = ST_EQUAL;
      end
      fieldzone = (sync_st != ST_NORMAL);

      case (sync_st)
         ST_BROAD: tv_sync_d = (hp >= BROAD_END);
         ST_EQUAL: tv_sync_d = (hp >= EQUAL_END);
         default:  tv_sync_d = (sc_q >= NORM_END);
      endcase

      tv_blank_d    = (sc_q < BLANK_LO) || (sc_q > BLANK_HI) || fieldzone;
      tv_burst_d    = (sc_q > BURST_LO) && (sc_q < BURST_HI) && !fieldzone;
      line_alt_d    = hl_q[1] ^ (alt_en & fld_q);
      field_d       = fld_q;
      field_start_d = fs_q;
      osd_vsync_d   = (hl_q != OSD_LINE);
      sample_d      = sc_q;
      halfline_d    = hl_q;
   end

   always_ff @(posedge clk24 or negedge reset_n) begin
      if (!reset_n) begin
         sc_q  <= '0;
         hl_q  <= '0;
         fld_q <= 1'b0;
         fs_q  <= 1'b0;
         vs_q  <= 1'b1;
      end else begin
         sc_q  <= sc_d;
         hl_q  <= hl_d;
         fld_q <= fld_d;
         fs_q  <= fs_d;
         vs_q  <= vs_d;
      end
   end

   always_ff @(posedge clk24 or negedge reset_n) begin
      if (!reset_n) begin
         tv_sync_q     <= 1'b1;
         tv_blank_q    <= 1'b1;
         tv_burst_q    <= 1'b0;
         line_alt_q    <= 1'b0;
         field_q       <= 1'b0;
         field_start_q <= 1'b0;
         osd_vsync_q   <= 1'b1;
         sample_q      <= '0;
         halfline_q    <= '0;
      end else if (ce) begin
         tv_sync_q     <= tv_sync_d;
         tv_blank_q    <= tv_blank_d;
         tv_burst_q    <= tv_burst_d;
         line_alt_q    <= line_alt_d;
         field_q       <= field_d;
         field_start_q <= field_start_d;
         osd_vsync_q   <= osd_vsync_d;
         sample_q      <= sample_d;
         halfline_q    <= halfline_d;
      end
   end

   assign tv_sync     = tv_sync_q;
   assign tv_blank    = tv_blank_q;
   assign tv_burst    = tv_burst_q;
   assign line_alt    = line_alt_q;
   assign field       = field_q;
   assign field_start = field_start_q;
   assign osd_vsync   = osd_vsync_q;
   assign sample      = sample_q;
   assign halfline    = halfline_q;

endmodule
